// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-port round-robin arbiter in front of a single-ported RAM with a fixed
// read latency. Port 0 is the ALU side, port 1 the loader/debug side. Each
// port holds a level request until its one-cycle ack. Every output comes
// straight from a flop.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   readReq0/1, writeReq0/1        per-port request levels
//   address0/1, dataIn0/1          per-port word address and write data
//   dataOut0/1, ack0/1             per-port read data and completion pulse
//   ramIn                          RAM read data
//   ramAddress, ramOut             RAM word address and write data
//   readReq, writeReq              RAM strobes, high for one cycle
//   mode                           debug view of the FSM state
//   grant                          port owning the current or last transaction
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | sample requests, arbitrate, latch address/data/op
// ISSUE | RAM strobe high for this one cycle
// WAIT  | read in flight; counter runs down to the ramIn capture edge
// ACK   | ack pulse to the granted port; requests are not sampled here
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        readReq0,
    input  logic        writeReq0,
    input  logic [31:0] address0,
    input  logic [31:0] dataIn0,
    output logic [31:0] dataOut0,
    output logic        ack0,
    input  logic        readReq1,
    input  logic        writeReq1,
    input  logic [31:0] address1,
    input  logic [31:0] dataIn1,
    output logic [31:0] dataOut1,
    output logic        ack1,
    input  logic [31:0] ramIn,
    output logic [31:0] ramAddress,
    output logic [31:0] ramOut,
    output logic        readReq,
    output logic        writeReq,
    output logic [7:0]  mode,
    output logic        grant
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] dout0_q, dout0_d;
    logic [31:0] dout1_q, dout1_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        req0, req1, win, win_wr;

    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        dout0_d      = dout0_q;
        dout1_d      = dout1_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;

        req0   = readReq0 | writeReq0;
        req1   = readReq1 | writeReq1;
        // With both ports requesting, the one not served last time wins.
        win    = (req0 && req1) ? ~last_grant_q : req1;
        // A port raising read and write together gets a write only.
        win_wr = win ? writeReq1 : writeReq0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_d      = win;
                    last_grant_d = win;
                    addr_d       = win ? address1 : address0;
                    wdata_d      = win ? dataIn1 : dataIn0;
                    wr_d         = win_wr;
                    rd_d         = ~win_wr;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rd_d = 1'b0;
                wr_d = 1'b0;
                if (wr_q) begin
                    state_d = S_ACK;
                    if (grant_q) ack1_d = 1'b1;
                    else         ack0_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(RAM_LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                    if (grant_q) begin
                        dout1_d = ramIn;
                        ack1_d  = 1'b1;
                    end else begin
                        dout0_d = ramIn;
                        ack0_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            dout0_q      <= 32'd0;
            dout1_q      <= 32'd0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            dout0_q      <= dout0_d;
            dout1_q      <= dout1_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign dataOut0   = dout0_q;
    assign dataOut1   = dout1_q;
    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign ramAddress = addr_q;
    assign ramOut     = wdata_q;
    assign readReq    = rd_q;
    assign writeReq   = wr_q;
    assign mode       = {6'd0, state_q};
    assign grant      = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    // main instance, RAM_LATENCY = 1
    logic        readReq0 = 0, writeReq0 = 0, readReq1 = 0, writeReq1 = 0;
    logic [31:0] address0 = 0, dataIn0 = 0, address1 = 0, dataIn1 = 0;
    logic [31:0] dataOut0, dataOut1, ramIn, ramAddress, ramOut;
    logic        ack0, ack1, readReq, writeReq, grant;
    logic [7:0]  mode;

    // second instance, RAM_LATENCY = 4 (port 0 only exercised)
    logic        readReq0_4 = 0;
    logic [31:0] address0_4 = 0;
    logic [31:0] dataOut0_4, dataOut1_4, ramIn_4, ramAddress_4, ramOut_4;
    logic        ack0_4, ack1_4, readReq_4, writeReq_4, grant_4;
    logic [7:0]  mode_4;

    mem_arbiter #(.RAM_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .readReq0(readReq0), .writeReq0(writeReq0), .address0(address0), .dataIn0(dataIn0),
        .dataOut0(dataOut0), .ack0(ack0),
        .readReq1(readReq1), .writeReq1(writeReq1), .address1(address1), .dataIn1(dataIn1),
        .dataOut1(dataOut1), .ack1(ack1),
        .ramIn(ramIn), .ramAddress(ramAddress), .ramOut(ramOut),
        .readReq(readReq), .writeReq(writeReq), .mode(mode), .grant(grant)
    );

    mem_arbiter #(.RAM_LATENCY(4)) dut4 (
        .clk(clk), .reset(reset),
        .readReq0(readReq0_4), .writeReq0(1'b0), .address0(address0_4), .dataIn0(32'd0),
        .dataOut0(dataOut0_4), .ack0(ack0_4),
        .readReq1(1'b0), .writeReq1(1'b0), .address1(32'd0), .dataIn1(32'd0),
        .dataOut1(dataOut1_4), .ack1(ack1_4),
        .ramIn(ramIn_4), .ramAddress(ramAddress_4), .ramOut(ramOut_4),
        .readReq(readReq_4), .writeReq(writeReq_4), .mode(mode_4), .grant(grant_4)
    );

    // RAM model: data becomes valid RAM_LATENCY edges after the read strobe edge
    logic [31:0] mem [16];
    int lat = 0, lat4 = 0;
    always @(posedge clk) begin
        if (reset) begin
            mem[2] <= 32'h7777F00D;
            mem[3] <= 32'h12345678;
        end else if (writeReq) begin
            mem[ramAddress[3:0]] <= ramOut;
        end
        if (readReq) lat <= 1;
        else if (lat > 0 && lat < 100) lat <= lat + 1;
        if (readReq_4) lat4 <= 1;
        else if (lat4 > 0 && lat4 < 100) lat4 <= lat4 + 1;
    end
    assign ramIn   = (lat >= 1)  ? mem[ramAddress[3:0]]   : 32'hBAD0BAD0;
    assign ramIn_4 = (lat4 >= 4) ? mem[ramAddress_4[3:0]] : 32'hBAD0BAD0;

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } strobe_t;
    typedef struct packed { logic port; logic we; logic [31:0] data; } ack_t;

    strobe_t sq[$];
    ack_t    aq[$];
    logic [31:0] exp_dout [2] = '{32'd0, 32'd0};
    int errors = 0;
    int checks = 0;

    // Monitor: compares every RAM strobe and every ack against the queues
    always @(negedge clk) begin
        strobe_t s;
        ack_t    a;
        logic [31:0] got, oth;
        logic p;
        if (!reset) begin
            if (readReq || writeReq) begin
                checks++;
                if (readReq && writeReq) begin
                    errors++;
                    $display("FAIL strobe_both: readReq=%b writeReq=%b, required one only", readReq, writeReq);
                end else if (sq.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected: we=%b addr=%h, required no strobe", writeReq, ramAddress);
                end else begin
                    s = sq.pop_front();
                    if (s.we != writeReq || ramAddress != s.addr || (s.we && ramOut != s.data) || mode != 8'd1) begin
                        errors++;
                        $display("FAIL strobe: we=%b addr=%h data=%h mode=%0d, required we=%b addr=%h data=%h mode=1",
                                 writeReq, ramAddress, ramOut, mode, s.we, s.addr, s.data);
                    end
                end
            end
            if (ack0 || ack1) begin
                checks++;
                if (ack0 && ack1) begin
                    errors++;
                    $display("FAIL ack_both: ack0=%b ack1=%b, required one only", ack0, ack1);
                end else if (aq.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected: ack0=%b ack1=%b, required none", ack0, ack1);
                end else begin
                    a   = aq.pop_front();
                    p   = ack1;
                    got = p ? dataOut1 : dataOut0;
                    oth = p ? dataOut0 : dataOut1;
                    if (!a.we) exp_dout[a.port] = a.data;
                    if (p != a.port || grant != a.port || got != exp_dout[a.port] || oth != exp_dout[~a.port]) begin
                        errors++;
                        $display("FAIL ack: port=%0d grant=%0d dout=%h other=%h, required port=%0d dout=%h other=%h",
                                 p, grant, got, oth, a.port, exp_dout[a.port], exp_dout[~a.port]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Issue one request on an idle arbiter, expect its ack after exp_lat edges
    task automatic run_req(input logic p, input logic re, input logic we,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input int exp_lat, input string name);
        int n = 0;
        bit seen = 0;
        @(negedge clk);
        sq.push_back('{we, a, d});
        aq.push_back('{p, we, exp_rd});
        if (p) begin readReq1 = re; writeReq1 = we; address1 = a; dataIn1 = d; end
        else   begin readReq0 = re; writeReq0 = we; address0 = a; dataIn0 = d; end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (p ? ack1 : ack0) seen = 1;
        end
        readReq0 = 0; writeReq0 = 0; readReq1 = 0; writeReq1 = 0;
        check({name, "_latency"}, seen ? n : -1, exp_lat);
    endtask

    initial begin
        int n, w;
        bit seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mode", mode, 8'd0);
        check("rst_strobes", {readReq, writeReq, ack0, ack1, grant}, 0);
        check("rst_dout0", dataOut0, 0);
        check("rst_dout1", dataOut1, 0);
        check("rst_ramaddr", ramAddress, 0);
        check("rst_ramout", ramOut, 0);
        reset = 0;

        run_req(0, 1, 0, 32'd2, 32'd0, 32'h7777F00D, 3, "p0_read");
        run_req(1, 0, 1, 32'd5, 32'hDEADBEEF, 32'd0, 2, "p1_write");
        check("mem5", mem[5], 32'hDEADBEEF);
        run_req(1, 1, 0, 32'd5, 32'd0, 32'hDEADBEEF, 3, "p1_read");

        // both ports hold read requests: grants must alternate starting at port 0
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sq.push_back('{1'b0, 32'd2, 32'd0});
            sq.push_back('{1'b0, 32'd3, 32'd0});
            aq.push_back('{1'b0, 1'b0, 32'h7777F00D});
            aq.push_back('{1'b1, 1'b0, 32'h12345678});
        end
        readReq0 = 1; address0 = 2; readReq1 = 1; address1 = 3;
        n = 0;
        for (int i = 0; i < 100 && n < 4; i++) begin
            @(negedge clk);
            if (ack0 || ack1) n++;
        end
        readReq0 = 0; readReq1 = 0;
        check("rr_acks", n, 4);

        // read+write together is a write; dataOut0 must stay 0x7777F00D
        run_req(0, 1, 1, 32'd7, 32'hCAFEF00D, 32'd0, 2, "p0_rdwr");
        check("mem7", mem[7], 32'hCAFEF00D);

        // reset during WAIT aborts the read; the held request is re-served
        @(negedge clk);
        sq.push_back('{1'b0, 32'd7, 32'd0});
        sq.push_back('{1'b0, 32'd7, 32'd0});
        aq.push_back('{1'b0, 1'b0, 32'hCAFEF00D});
        readReq0 = 1; address0 = 7;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mode == 8'd2) seen = 1;
        end
        check("wait_reached", seen, 1);
        reset = 1;
        exp_dout[0] = 0; exp_dout[1] = 0;
        @(posedge clk);
        @(negedge clk);
        check("abort_mode", mode, 8'd0);
        check("abort_strobe", {readReq, writeReq}, 0);
        check("abort_ack0", ack0, 0);
        check("abort_dout0", dataOut0, 0);
        reset = 0;
        n = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (ack0) seen = 1;
        end
        readReq0 = 0;
        check("reserve_latency", seen ? n : -1, 3);

        // RAM_LATENCY = 4 instance
        @(negedge clk);
        readReq0_4 = 1; address0_4 = 2;
        n = 0; w = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (mode_4 == 8'd2) w++;
            if (ack0_4) seen = 1;
        end
        readReq0_4 = 0;
        check("lat4_latency", seen ? n : -1, 6);
        check("lat4_wait_cycles", w, 4);
        check("lat4_dout0", dataOut0_4, 32'h7777F00D);

        repeat (3) @(negedge clk);
        check("strobe_queue_left", sq.size(), 0);
        check("ack_queue_left", aq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: RAM_LATENCY, default 1, edges from the readReq-high edge to ramIn valid; legal range 1..15.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 readReq0  input  1  port 0 (ALU) read request, level, held until ack0.
REQ-005 writeReq0  input  1  port 0 write request, level, held until ack0.
REQ-006 address0  input  32  port 0 RAM word address.
REQ-007 dataIn0  input  32  port 0 write data.
REQ-008 dataOut0  output  32  port 0 read data, valid from ack0 until port 0's next read completes.
REQ-009 ack0  output  1  port 0 completion pulse, one cycle.
REQ-010 readReq1, writeReq1, address1, dataIn1, dataOut1, ack1: same widths and meaning for port 1 (loader/debug).
REQ-011 ramIn  input  32  RAM read data.
REQ-012 ramAddress  output  32  RAM word address.
REQ-013 ramOut  output  32  RAM write data.
REQ-014 readReq  output  1  RAM read strobe.
REQ-015 writeReq  output  1  RAM write strobe.
REQ-016 mode  output  8  FSM state (debug): 0 IDLE, 1 ISSUE, 2 WAIT, 3 ACK.
REQ-017 grant  output  1  index of the port owning the current or last transaction.

Function
REQ-018 All outputs SHALL be registered; no combinational input-to-output path.
REQ-019 IDLE: requests sampled only in IDLE; port p requests when readReqp or writeReqp is high.
REQ-020 Arbitration: one requester wins; both request: port != lastGrant wins (round-robin); lastGrant updates on every grant.
REQ-021 On grant: latch address, data, op into ramAddress/ramOut; assert readReq or writeReq; grant <= winner; mode <= ISSUE.
REQ-022 Both readReqp and writeReqp high on the winning port: treated as write; no read performed.
REQ-023 ISSUE lasts exactly one cycle; strobe is high only during ISSUE; leaving ISSUE clears readReq/writeReq.
REQ-024 Write: ISSUE -> ACK directly.
REQ-025 Read: ISSUE -> WAIT; 4-bit counter loaded with RAM_LATENCY-1 on entry; WAIT exits when counter is 0, else decrements.
REQ-026 On the WAIT exit edge: dataOutGrant <= ramIn; ackGrant <= 1; mode <= ACK. With RAM_LATENCY=1, WAIT lasts one cycle.
REQ-027 ACK lasts exactly one cycle; ack cleared on exit; mode <= IDLE; no request sampled in ACK.
REQ-028 A request still high at the IDLE sample after ACK is a new transaction (back-to-back allowed).
REQ-029 Non-granted port waits with no side effects; its dataOut and ack are unchanged.
REQ-030 Read latency, sample edge to ack high: 2 + RAM_LATENCY edges; write latency: 2 edges.
REQ-031 ramAddress/ramOut hold their last values in non-ISSUE states; they are don't-care while both strobes are low.
REQ-032 Only one RAM strobe is ever high; never both.

Reset
REQ-033 On reset at a rising edge, regardless of state: mode=0, readReq=0, writeReq=0, ack0=ack1=0, dataOut0=dataOut1=0, ramAddress=0, ramOut=0, grant=0, lastGrant=1, counter=0.
REQ-034 Reset mid-transaction SHALL abort it with no ack; requests held through reset are re-arbitrated at the first IDLE edge after reset deasserts.

Verification
REQ-035 Port 0 read, address0=2, RAM word 2=0x7777F00D, RAM_LATENCY=1 -> readReq high one cycle with ramAddress=2; ack0 high 3 edges after sample; dataOut0=0x7777F00D.
REQ-036 Port 1 write, address1=5, dataIn1=0xDEADBEEF -> writeReq high one cycle with ramAddress=5, ramOut=0xDEADBEEF; ack1 2 edges after sample; RAM word 5 updated.
REQ-037 Both ports continuously request reads after reset -> grants alternate 0,1,0,1; neither port gets two consecutive grants.
REQ-038 Reset asserted during WAIT of port 0 read -> next cycle mode=0, readReq=0, no ack0, dataOut0=0; held request is re-served after reset deasserts.
REQ-039 RAM_LATENCY=4, port 0 read -> WAIT lasts 4 cycles; ack0 6 edges after sample; ramIn captured on WAIT exit edge.
REQ-040 Port 0 asserts readReq0 and writeReq0 together -> only writeReq pulses; dataOut0 unchanged; ack0 after 2 edges.
